// File: rtl/axis_boxcar_decim_mc.sv
// rtl/axis_boxcar_decim_mc.sv - multi-channel integrate-and-dump decimator with scale, saturate and EOB flush
// Sums D beats per I/Q component, shifts and clamps on dump; the output register is the only storage.
module axis_boxcar_decim_mc #(
    parameter int NUM_CH    = 2,
    parameter int SAMP_W    = 16,
    parameter int MAX_DECIM = 255,
    parameter int DECIM_W   = 8,
    parameter int SHIFT_W   = 4,
    parameter int ACC_W     = SAMP_W + $clog2(MAX_DECIM + 1)
) (
    input  logic                         ce_clk,
    input  logic                         ce_rst_n,
    input  logic [DECIM_W-1:0]           cfg_decim,
    input  logic [SHIFT_W-1:0]           cfg_shift,
    input  logic                         cfg_drop_partial,
    input  logic                         cfg_clear_stat,
    input  logic [NUM_CH*2*SAMP_W-1:0]   s_axis_tdata,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [NUM_CH*2*SAMP_W-1:0]   m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         stat_sat
);

    localparam int NC = 2 * NUM_CH;
    localparam int TW = NC * SAMP_W;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                     state_q, state_d;
    logic [DECIM_W-1:0]         d_l_q, d_l_d;
    logic [SHIFT_W-1:0]         shift_l_q, shift_l_d;
    logic [DECIM_W-1:0]         count_q, count_d;
    logic [NC-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [TW-1:0]              m_tdata_q, m_tdata_d;
    logic                       m_tlast_q, m_tlast_d;
    logic                       m_tvalid_q, m_tvalid_d;
    logic                       stat_q, stat_d;
    logic                       rdy_q;

    logic                       accept;
    logic [DECIM_W-1:0]         eff_d;
    logic [SHIFT_W-1:0]         eff_shift;
    logic [DECIM_W-1:0]         cnt_inc;
    logic                       full, dump, drop_eob, sat_any;
    logic [NC-1:0][ACC_W-1:0]   sum;
    logic [TW-1:0]              scaled;
    logic [SAMP_W:0]            res;

    // Returns {clamped, value}: arithmetic shift then clamp to the SAMP_W signed range.
    function automatic logic [SAMP_W:0] scale_sat(input logic [ACC_W-1:0] a,
                                                  input logic [SHIFT_W-1:0] sh);
        logic signed [ACC_W-1:0] s;
        s = $signed(a) >>> sh;
        if ((&s[ACC_W-1:SAMP_W-1]) || !(|s[ACC_W-1:SAMP_W-1]))
            return {1'b0, s[SAMP_W-1:0]};
        else if (s[ACC_W-1])
            return {1'b1, 1'b1, {(SAMP_W-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(SAMP_W-1){1'b1}}};
    endfunction

    assign s_axis_tready = rdy_q && (!m_tvalid_q || m_axis_tready);
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign stat_sat      = stat_q;

    always_comb begin
        state_d    = state_q;
        d_l_d      = d_l_q;
        shift_l_d  = shift_l_q;
        count_d    = count_q;
        acc_d      = acc_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        sat_any    = 1'b0;
        scaled     = '0;
        res        = '0;
        sum        = '0;

        accept    = s_axis_tvalid && s_axis_tready;
        // Config is only sampled on the first beat of a burst.
        eff_d     = (state_q == IDLE) ? ((cfg_decim == '0) ? DECIM_W'(1) : cfg_decim) : d_l_q;
        eff_shift = (state_q == IDLE) ? cfg_shift : shift_l_q;
        cnt_inc   = count_q + DECIM_W'(1);
        full      = (cnt_inc == eff_d);
        dump      = full || s_axis_tlast;
        drop_eob  = s_axis_tlast && !full && cfg_drop_partial;

        for (int k = 0; k < NC; k++) begin
            sum[k] = {{(ACC_W-SAMP_W){s_axis_tdata[k*SAMP_W+SAMP_W-1]}},
                      s_axis_tdata[k*SAMP_W +: SAMP_W]};
            if (count_q != '0)
                sum[k] = acc_q[k] + sum[k];
            res = scale_sat(sum[k], eff_shift);
            scaled[k*SAMP_W +: SAMP_W] = res[SAMP_W-1:0];
            sat_any = sat_any | res[SAMP_W];
        end

        if (m_axis_tready)
            m_tvalid_d = 1'b0;

        if (accept) begin
            if (state_q == IDLE) begin
                d_l_d     = eff_d;
                shift_l_d = eff_shift;
            end
            state_d = s_axis_tlast ? IDLE : ACCUM;
            if (dump) begin
                count_d    = '0;
                m_tvalid_d = 1'b1;
                m_tlast_d  = s_axis_tlast;
                m_tdata_d  = drop_eob ? '0 : scaled;
            end else begin
                count_d = cnt_inc;
                acc_d   = sum;
            end
        end

        stat_d = (cfg_clear_stat ? 1'b0 : stat_q) | (accept && dump && !drop_eob && sat_any);
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_q    <= IDLE;
            d_l_q      <= DECIM_W'(1);
            shift_l_q  <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            stat_q     <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_l_q      <= d_l_d;
            shift_l_q  <= shift_l_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
            stat_q     <= stat_d;
            rdy_q      <= 1'b1;
        end
    end

endmodule
